// File: rtl/fetch_stage.sv
// Stage-1 instruction fetch: owns the PC, handshakes with instruction memory, fills one slot per cycle.
// Latency: a response in cycle N is in the slot after edge N. Redirect bubbles the slot at the branch edge.
// Backpressure: stall freezes the slot. A response that lands under stall goes to a one-entry hold (skid).
module fetch_stage #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     OP_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [OP_W-1:0] imem_data,
  input  logic            imem_valid,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] PC,
  output logic [OP_W-1:0] IR,
  output logic            BB
);

  // HOLD: a response is parked in the skid entry while stall is high.
  // DRAIN: a redirect arrived with a request still in flight. That response must be swallowed.
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] redirect;
  logic [PC_W-1:0] hold_pc1;
  logic [OP_W-1:0] hold_op;
  logic [PC_W-1:0] pc_inc;

  // Modulo-2^PC_W increment, so the address FFFF wraps to 0000.
  assign pc_inc = pc + PC_W'(1);

  // The request is decoded from registered state only. Memory never sees a combinational path from stage 2.
  assign imem_req  = (state != HOLD);
  assign imem_addr = pc;

  // Fetch FSM. Priority is branch, then stall, then normal flow. Every bubble write clears IR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      redirect <= '0;
      hold_pc1 <= '0;
      hold_op  <= '0;
      PC       <= '0;
      IR       <= '0;
      BB       <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (branch_taken) begin
            PC <= pc_inc;
            IR <= '0;
            BB <= 1'b1;
            if (imem_valid) begin
              // The in-flight response lands now, so its data is dropped and we restart at once.
              pc <= branch_target;
            end else begin
              redirect <= branch_target;
              state    <= DRAIN;
            end
          end else if (imem_valid) begin
            pc <= pc_inc;
            if (stall) begin
              hold_pc1 <= pc_inc;
              hold_op  <= imem_data;
              state    <= HOLD;
            end else begin
              PC <= pc_inc;
              IR <= imem_data;
              BB <= 1'b0;
            end
          end else if (!stall) begin
            PC <= pc_inc;
            IR <= '0;
            BB <= 1'b1;
          end
        end

        HOLD: begin
          if (branch_taken) begin
            // The held instruction is on the wrong path. Drop it and restart at the target.
            PC    <= pc_inc;
            IR    <= '0;
            BB    <= 1'b1;
            pc    <= branch_target;
            state <= FETCH;
          end else if (!stall) begin
            PC    <= hold_pc1;
            IR    <= hold_op;
            BB    <= 1'b0;
            state <= FETCH;
          end
        end

        DRAIN: begin
          if (branch_taken) begin
            // If several redirects arrive while draining, the latest one is kept.
            redirect <= branch_target;
            PC       <= pc_inc;
            IR       <= '0;
            BB       <= 1'b1;
          end else if (!stall) begin
            PC <= pc_inc;
            IR <= '0;
            BB <= 1'b1;
          end
          if (imem_valid) begin
            pc    <= branch_taken ? branch_target : redirect;
            state <= FETCH;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. Expected slots are queued when a response is driven.
// They are popped and compared when a non-bubble slot appears.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [7:0]  imem_data = '0;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic [15:0] PC;
  logic [7:0]  IR;
  logic        BB;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] sb_pc[$];
  logic [7:0]  sb_ir[$];

  fetch_stage #(.PC_W(16), .OP_W(8), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .PC(PC), .IR(IR), .BB(BB)
  );

  always #5 clk = ~clk;

  // Memory contents: a few fixed opcodes, otherwise derived from the address.
  function automatic logic [7:0] op_of(input logic [15:0] a);
    case (a)
      16'h0005: return 8'h44;
      16'hFFFF: return 8'h55;
      default:  return 8'((a[7:0] + 8'd1) * 8'd17);
    endcase
  endfunction

  // Outputs are sampled 1 time unit after the rising edge. Inputs are driven at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder with fixed latency. Each non-bubble slot is popped and compared.
  task automatic run_mem(input int lat, input int n_instr, input string tag);
    int          wait_c = 0;
    int          got = 0;
    logic [15:0] a_prev;
    logic        drove;
    for (int c = 0; c < 40 && got < n_instr; c++) begin
      drove = 1'b0;
      if (imem_req && wait_c == lat - 1) begin
        imem_valid = 1'b1;
        imem_data  = op_of(imem_addr);
        sb_pc.push_back(imem_addr + 16'd1);
        sb_ir.push_back(imem_data);
        wait_c = 0;
        drove  = 1'b1;
      end else begin
        imem_valid = 1'b0;
        if (imem_req) wait_c++;
      end
      a_prev = imem_addr;
      step();
      imem_valid = 1'b0;
      n_cmp++;
      if (BB === 1'b0) begin
        if (sb_pc.size() == 0) begin
          n_bad++;
          $display("FAIL %s unexpected_slot: got PC=%h IR=%h, required none", tag, PC, IR);
        end else begin
          logic [15:0] epc;
          logic [7:0]  eir;
          epc = sb_pc.pop_front();
          eir = sb_ir.pop_front();
          got++;
          if (PC !== epc || IR !== eir) begin
            n_bad++;
            $display("FAIL %s slot: got PC=%h IR=%h, required PC=%h IR=%h", tag, PC, IR, epc, eir);
          end
        end
      end else begin
        if (IR !== 8'h00 || BB !== 1'b1 || lat == 1) begin
          n_bad++;
          $display("FAIL %s bubble: got BB=%b IR=%h, required %s", tag, BB, IR,
                   (lat == 1) ? "BB=0 every cycle" : "BB=1 IR=00");
        end
      end
      if (!drove) begin
        n_cmp++;
        if (imem_addr !== a_prev) begin
          n_bad++;
          $display("FAIL %s addr_stable: got %h, required %h", tag, imem_addr, a_prev);
        end
      end
    end
    n_cmp++;
    if (got < n_instr) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d instructions, required %0d", tag, got, n_instr);
    end
  endtask

  // Redirect from FETCH while a response lands in the same cycle. This jumps directly to t.
  task automatic redirect_to(input logic [15:0] t);
    branch_taken  = 1'b1;
    branch_target = t;
    imem_valid    = 1'b1;
    imem_data     = 8'hEE;
    step();
    branch_taken = 1'b0;
    imem_valid   = 1'b0;
    n_cmp++;
    if (BB !== 1'b1 || IR !== 8'h00 || imem_addr !== t || imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL redirect: got BB=%b IR=%h addr=%h req=%b, required BB=1 IR=00 addr=%h req=1",
               BB, IR, imem_addr, imem_req, t);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (PC !== 16'h0000 || IR !== 8'h00 || BB !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset: got PC=%h IR=%h BB=%b req=%b addr=%h, required 0000 00 1 1 0000",
               PC, IR, BB, imem_req, imem_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    run_mem(1, 3, "zero_wait");
    n_cmp++;
    if (imem_addr !== 16'h0003) begin
      n_bad++;
      $display("FAIL zero_wait_addr: got %h, required 0003", imem_addr);
    end
  endtask

  task automatic test_latency();
    run_mem(2, 3, "latency2");
    run_mem(3, 2, "latency3");
  endtask

  task automatic test_stall();
    redirect_to(16'h0004);
    run_mem(1, 1, "stall_pre");
    // A response under stall must leave the slot alone and drop the request.
    stall      = 1'b1;
    imem_valid = 1'b1;
    imem_data  = op_of(imem_addr);
    sb_pc.push_back(imem_addr + 16'd1);
    sb_ir.push_back(imem_data);
    step();
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (PC !== 16'h0005 || IR !== 8'h55 || BB !== 1'b0 || imem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got PC=%h IR=%h BB=%b req=%b, required 0005 55 0 0",
                 i, PC, IR, BB, imem_req);
      end
      if (i < 2) step();
    end
    stall = 1'b0;
    step();
    n_cmp++;
    if (BB !== 1'b0 || sb_pc.size() == 0 || PC !== sb_pc[0] || IR !== sb_ir[0]) begin
      n_bad++;
      $display("FAIL stall_release: got PC=%h IR=%h BB=%b, required PC=0006 IR=44 BB=0", PC, IR, BB);
    end
    if (sb_pc.size() != 0) begin
      void'(sb_pc.pop_front());
      void'(sb_ir.pop_front());
    end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
      n_bad++;
      $display("FAIL stall_next_req: got req=%b addr=%h, required 1 0006", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_drain();
    redirect_to(16'h0010);
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (BB !== 1'b1 || IR !== 8'h00 || imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
        n_bad++;
        $display("FAIL drain_wait[%0d]: got BB=%b IR=%h req=%b addr=%h, required 1 00 1 0010",
                 i, BB, IR, imem_req, imem_addr);
      end
      if (i < 2) step();
    end
    imem_valid = 1'b1;
    imem_data  = 8'hAA;
    step();
    imem_valid = 1'b0;
    n_cmp++;
    if (BB !== 1'b1 || IR !== 8'h00 || imem_addr !== 16'h0100) begin
      n_bad++;
      $display("FAIL drain_done: got BB=%b IR=%h addr=%h, required 1 00 0100", BB, IR, imem_addr);
    end
    run_mem(1, 2, "after_branch");
    // When two redirects arrive during a drain, the later one wins.
    redirect_to(16'h0030);
    branch_taken  = 1'b1;
    branch_target = 16'h0300;
    step();
    branch_target = 16'h0200;
    step();
    branch_taken = 1'b0;
    imem_valid   = 1'b1;
    imem_data    = 8'hBB;
    step();
    imem_valid = 1'b0;
    n_cmp++;
    if (imem_addr !== 16'h0200 || BB !== 1'b1) begin
      n_bad++;
      $display("FAIL latest_wins: got addr=%h BB=%b, required 0200 1", imem_addr, BB);
    end
    run_mem(1, 1, "after_latest");
  endtask

  task automatic test_hold_branch();
    redirect_to(16'h0020);
    stall      = 1'b1;
    imem_valid = 1'b1;
    imem_data  = op_of(16'h0020);
    step();
    imem_valid = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_enter: got req=%b, required 0", imem_req);
    end
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    step();
    branch_taken = 1'b0;
    stall        = 1'b0;
    n_cmp++;
    if (BB !== 1'b1 || IR !== 8'h00 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      n_bad++;
      $display("FAIL hold_branch: got BB=%b IR=%h req=%b addr=%h, required 1 00 1 0040",
               BB, IR, imem_req, imem_addr);
    end
    run_mem(1, 1, "hold_flushed");
  endtask

  task automatic test_wrap();
    redirect_to(16'hFFFF);
    run_mem(1, 1, "wrap");
    n_cmp++;
    if (PC !== 16'h0000 || IR !== 8'h55 || imem_addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_addr: got PC=%h IR=%h addr=%h, required 0000 55 0000", PC, IR, imem_addr);
    end
    run_mem(1, 1, "wrap_next");
  endtask

  task automatic test_reset_mid();
    redirect_to(16'h0077);
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (PC !== 16'h0000 || IR !== 8'h00 || BB !== 1'b1 || imem_addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_mid: got PC=%h IR=%h BB=%b addr=%h, required 0000 00 1 0000",
               PC, IR, BB, imem_addr);
    end
    step();
    rst_n = 1'b1;
    run_mem(1, 2, "post_reset");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_branch_drain();
    test_hold_branch();
    test_wrap();
    test_reset_mid();
    n_cmp++;
    if (sb_pc.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb_pc.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
